// File: rtl/io_input_conditioner_pkg.sv
// Shared types and constants for the switch/key input conditioner.
// Debounce defaults target a 50 MHz core clock (10 ms window).
package io_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } key_state_t;

  localparam int GPIO_W              = 32;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

endpackage

// File: rtl/io_input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the input conditioner.
// master = board/consumer side, slave = conditioner side.
interface io_input_conditioner_if #(
  parameter int SW_WIDTH  = 18,
  parameter int KEY_WIDTH = 4
);
  import io_pkg::*;

  logic [SW_WIDTH-1:0]  sw_raw;
  logic [KEY_WIDTH-1:0] key_raw;
  logic [SW_WIDTH-1:0]  sw_stable;
  logic                 sw_changed;
  logic [KEY_WIDTH-1:0] key_level;
  logic [KEY_WIDTH-1:0] key_press;
  logic [KEY_WIDTH-1:0] key_release;
  logic [GPIO_W-1:0]    gpio_in;

  modport master (
    output sw_raw, key_raw,
    input  sw_stable, sw_changed, key_level, key_press, key_release, gpio_in
  );

  modport slave (
    input  sw_raw, key_raw,
    output sw_stable, sw_changed, key_level, key_press, key_release, gpio_in
  );

endinterface

// File: rtl/io_input_conditioner_key_debounce.sv
// One push-button: 2-flop synchronizer, 4-state debounce FSM, press/release pulses.
// Latency 2 + DEBOUNCE_CYCLES cycles from a clean raw edge; no backpressure.
module key_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta_q, key_sync_q;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d, release_q, release_d;

  // Raw key is active-low: sync value 0 means the button is held.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_inc   = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      RELEASED: begin
        if (!key_sync_q) begin
          state_d = PRESS_PEND;
          cnt_d   = '0;
        end
      end
      PRESS_PEND: begin
        if (key_sync_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (key_sync_q) begin
          state_d = RELEASE_PEND;
          cnt_d   = '0;
        end
      end
      RELEASE_PEND: begin
        if (!key_sync_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      state_q    <= RELEASED;
      cnt_q      <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      key_meta_q <= key_raw_i;
      key_sync_q <= key_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign key_level_o   = (state_q == PRESSED) || (state_q == RELEASE_PEND);
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces slide switches (shared debouncer) and push-buttons (per-key FSM).
// Latency 2 + DEBOUNCE_CYCLES cycles from a clean raw edge; no backpressure.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int SW_WIDTH        = 18,
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  io_input_conditioner_if.slave bus
);
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q, sw_prev_q;
  logic [SW_WIDTH-1:0]  sw_stable_q, sw_stable_d;
  logic [CNT_W-1:0]     sw_cnt_q, sw_cnt_d, sw_cnt_inc;
  logic                 sw_changed_q, sw_changed_d;
  logic                 sw_load;
  logic [KEY_WIDTH-1:0] key_level, key_press, key_release;

  // Any bit moving restarts the window; a full quiet window that disagrees with
  // the published word loads it.
  always_comb begin
    sw_cnt_inc   = (sw_cnt_q == CNT_LAST) ? sw_cnt_q : sw_cnt_q + CNT_W'(1);
    sw_cnt_d     = (sw_sync_q != sw_prev_q) ? '0 : sw_cnt_inc;
    sw_load      = (sw_sync_q == sw_prev_q) && (sw_cnt_inc == CNT_LAST) &&
                   (sw_sync_q != sw_stable_q);
    sw_stable_d  = sw_load ? sw_sync_q : sw_stable_q;
    sw_changed_d = sw_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      sw_prev_q    <= '0;
      sw_cnt_q     <= '0;
      sw_stable_q  <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      sw_meta_q    <= bus.sw_raw;
      sw_sync_q    <= sw_meta_q;
      sw_prev_q    <= sw_sync_q;
      sw_cnt_q     <= sw_cnt_d;
      sw_stable_q  <= sw_stable_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  for (genvar k = 0; k < KEY_WIDTH; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_raw_i    (bus.key_raw[k]),
      .key_level_o  (key_level[k]),
      .key_press_o  (key_press[k]),
      .key_release_o(key_release[k])
    );
  end

  assign bus.sw_stable   = sw_stable_q;
  assign bus.sw_changed  = sw_changed_q;
  assign bus.key_level   = key_level;
  assign bus.key_press   = key_press;
  assign bus.key_release = key_release;
  assign bus.gpio_in     = GPIO_W'(sw_stable_q);

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed plus random stimulus against a sliding-window debounce model.
module tb_io_input_conditioner;
  localparam int D  = 4;
  localparam int SW = 18;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  io_input_conditioner_if #(.SW_WIDTH(SW), .KEY_WIDTH(KW)) bus ();

  io_input_conditioner #(
    .SW_WIDTH(SW),
    .KEY_WIDTH(KW),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Model: a debounced output takes a new value once the last D synchronized
  // samples (raw delayed by two cycles) all agree on it.
  logic [SW-1:0] sw_hist[$];
  logic [KW-1:0] key_hist[$];
  logic [SW-1:0] m_stable;
  logic          m_changed;
  logic [KW-1:0] m_level, m_press, m_release;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sw_hist.delete();
    key_hist.delete();
    for (int i = 0; i < D + 2; i++) begin
      sw_hist.push_back('0);
      key_hist.push_back('1);
    end
    m_stable  = '0;
    m_changed = 1'b0;
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
  endtask

  task automatic model_edge();
    int            last;
    logic [SW-1:0] w;
    logic [KW-1:0] kv;
    logic          all_eq;
    logic [KW-1:0] all_p, all_r;
    last   = sw_hist.size() - 1;
    w      = sw_hist[last-2];
    all_eq = 1'b1;
    all_p  = '1;
    all_r  = '1;
    for (int i = 0; i < D; i++) begin
      if (sw_hist[last-2-i] != w) all_eq = 1'b0;
      kv = key_hist[last-2-i];
      all_p = all_p & ~kv;
      all_r = all_r & kv;
    end
    m_changed = all_eq && (w != m_stable);
    if (m_changed) m_stable = w;
    m_press   = ~m_level & all_p;
    m_release = m_level & all_r;
    m_level   = (m_level | m_press) & ~m_release;
  endtask

  task automatic check_outputs();
    check("sw_stable",   32'(bus.sw_stable),   32'(m_stable));
    check("sw_changed",  32'(bus.sw_changed),  32'(m_changed));
    check("key_level",   32'(bus.key_level),   32'(m_level));
    check("key_press",   32'(bus.key_press),   32'(m_press));
    check("key_release", 32'(bus.key_release), 32'(m_release));
    check("gpio_in",     bus.gpio_in,          32'(m_stable));
  endtask

  task automatic tick();
    sw_hist.push_back(bus.sw_raw);
    key_hist.push_back(bus.key_raw);
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sw_stable"},  32'(bus.sw_stable),   32'd0);
    check({tag, "_sw_changed"}, 32'(bus.sw_changed),  32'd0);
    check({tag, "_key_level"},  32'(bus.key_level),   32'd0);
    check({tag, "_key_press"},  32'(bus.key_press),   32'd0);
    check({tag, "_key_rel"},    32'(bus.key_release), 32'd0);
    check({tag, "_gpio_in"},    bus.gpio_in,          32'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check_zero("rst_enter");
    repeat (n) @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int chg;
    int act;
    int idx;
    bus.sw_raw  = SW'(42);
    bus.key_raw = '1;
    model_reset();

    // Reset with switches at 42: word appears 6 cycles after release, one pulse.
    do_reset(3);
    chg = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chg += int'(bus.sw_changed);
      if (i == 5) check("sw42_early", 32'(bus.sw_stable), 32'd0);
      if (i == 6) begin
        check("sw42_stable", 32'(bus.sw_stable), 32'd42);
        check("sw42_gpio", bus.gpio_in, 32'h2A);
        check("sw42_pulse", 32'(bus.sw_changed), 32'd1);
      end
    end
    check("sw42_pulse_count", 32'(chg), 32'd1);

    // Key 1 press and release, 6 cycles each.
    bus.key_raw[1] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check("k1_level_early", 32'(bus.key_level[1]), 32'd0);
    end
    check("k1_level", 32'(bus.key_level[1]), 32'd1);
    check("k1_press", 32'(bus.key_press[1]), 32'd1);
    bus.key_raw[1] = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    check("k1_release", 32'(bus.key_release[1]), 32'd1);
    check("k1_level_off", 32'(bus.key_level[1]), 32'd0);

    // Key 2 glitch of 3 cycles: no activity.
    act = 0;
    bus.key_raw[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      act += int'(bus.key_level[2] | bus.key_press[2] | bus.key_release[2]);
    end
    bus.key_raw[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      act += int'(bus.key_level[2] | bus.key_press[2] | bus.key_release[2]);
    end
    check("k2_glitch_activity", 32'(act), 32'd0);

    // Switches 42 -> 100 (2 cycles) -> 123 held.
    chg = 0;
    bus.sw_raw = SW'(100);
    for (int i = 0; i < 2; i++) begin
      tick();
      chg += int'(bus.sw_changed);
    end
    bus.sw_raw = SW'(123);
    for (int i = 0; i < 8; i++) begin
      tick();
      chg += int'(bus.sw_changed);
    end
    check("sw123_pulse_count", 32'(chg), 32'd1);
    check("sw123_stable", 32'(bus.sw_stable), 32'd123);
    check("sw123_gpio", bus.gpio_in, 32'h7B);

    // Key 0 low, reset during PRESS_PEND, press 6 cycles after release.
    bus.key_raw[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    do_reset(2);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check("k0_rst_press_early", 32'(bus.key_press[0]), 32'd0);
    end
    check("k0_rst_press", 32'(bus.key_press[0]), 32'd1);
    check("k0_rst_level", 32'(bus.key_level), 32'b0001);
    for (int i = 0; i < 4; i++) tick();

    // Keys 0 and 3 fall together.
    bus.key_raw[0] = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.key_raw[0] = 1'b0;
    bus.key_raw[3] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("k03_press", 32'(bus.key_press), 32'b1001);
    check("k03_level", 32'(bus.key_level), 32'b1001);
    bus.key_raw = '1;
    for (int i = 0; i < 8; i++) tick();

    // Random bouncing on switches and keys, with one reset in the middle.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0)
        bus.sw_raw = ($urandom_range(0, 3) == 0) ? m_stable : SW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, KW - 1));
        bus.key_raw[idx] = ~bus.key_raw[idx];
      end
      if (c == 200) do_reset(3);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

Input-side conditioning stage between the board's raw slide switches/push-buttons and the RISC-V CPU's GPIO input port. It synchronizes `SW` and `KEY` into the core clock domain, debounces them, and presents a stable switch word plus per-key level and edge pulses. The CPU firmware reads `gpio_in`; with this stage in place, the binary-to-decimal conversion never sees a metastable or bouncing value.

## Interface
- `SW_WIDTH`, 18, number of slide switches.
- `KEY_WIDTH`, 4, number of push-buttons.
- `DEBOUNCE_CYCLES`, 500000, stable cycles required before accepting a change (10 ms at 50 MHz); legal minimum 2.
- `clk`  in  1  core clock (`CLOCK_50` domain).
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `sw_raw`  in  SW_WIDTH  raw switch levels, asynchronous.
- `key_raw`  in  KEY_WIDTH  raw buttons, active-low (0 = pressed), asynchronous.
- `sw_stable`  out  SW_WIDTH  debounced switch word.
- `sw_changed`  out  1  one-cycle pulse when `sw_stable` updates.
- `key_level`  out  KEY_WIDTH  debounced key state, active-high (1 = pressed).
- `key_press`  out  KEY_WIDTH  one-cycle pulse per bit on the debounced press.
- `key_release`  out  KEY_WIDTH  one-cycle pulse per bit on the debounced release.
- `gpio_in`  out  32  `{zero-extend, sw_stable}` for the CPU GPIO read port.

## Operation
- Two-flop synchronizer on every `sw_raw` and `key_raw` bit. Reset values: switch flops 0, key flops 1 (released).
- Per key, 4-state FSM with its own counter (width `$clog2(DEBOUNCE_CYCLES)`):
  - RELEASED: synced key = 0 -> PRESS_PEND, counter = 0.
  - PRESS_PEND: synced = 1 (bounce) -> RELEASED, counter cleared. Otherwise, increment; at `DEBOUNCE_CYCLES-1` -> PRESSED, pulse `key_press`.
  - PRESSED: synced key = 1 -> RELEASE_PEND, counter = 0.
  - RELEASE_PEND: synced = 0 -> PRESSED. Otherwise, count; at `DEBOUNCE_CYCLES-1` -> RELEASED, pulse `key_release`.
  - `key_level` = 1 in PRESSED and RELEASE_PEND.
- Switch word uses one shared debouncer:
  - Register the previous synced vector. Any bit difference restarts the counter at 0.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the synced vector differs from `sw_stable`, load `sw_stable` and pulse `sw_changed`.
  - If the vector returns to `sw_stable` before that point, no update and no pulse.
- Counters saturate; they never wrap.
- Reset values: `sw_stable`=0, `sw_changed`=0, `key_level`=0, `key_press`=0, `key_release`=0, `gpio_in`=0, every FSM in RELEASED, counters 0.
- Reset mid-operation: all pending counts are discarded. After `rst_n` deasserts, inputs are re-evaluated from scratch.
- Keys are independent. Simultaneous events on several keys produce same-cycle pulses. A key event and a switch update in the same cycle are both reported.

## Timing
- Raw edge to synced value: 2 cycles.
- Clean raw edge to `key_level`/`key_press`/`key_release`/`sw_stable`/`sw_changed` change: 2 + DEBOUNCE_CYCLES cycles, all registered outputs.
- Pulses are exactly 1 cycle wide. A pulse coincides with the cycle its level output changes.
- Any glitch shorter than DEBOUNCE_CYCLES synced cycles produces no output change.
- `gpio_in` follows `sw_stable` in the same cycle (wiring only).

## Structure
- Package `io_pkg`:
  - `key_state_t` enum {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND}.
  - `GPIO_W` = 32.
  - Default `DEBOUNCE_CYCLES`.
- Sub-module `key_debounce`: one synchronizer, FSM and counter per key, instantiated KEY_WIDTH times via generate.
- The switch debouncer lives in the top of this block.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset with `sw_raw`=42 -> all outputs 0 during reset. After release: `sw_stable`=42 and `gpio_in`=0x2A exactly 6 cycles later, single `sw_changed` pulse.
- `key_raw[1]` 1->0 held -> `key_level[1]`=1 and one `key_press[1]` pulse 6 cycles after the edge. Return to 1 -> `key_release[1]` pulse 6 cycles later.
- `key_raw[2]` low for 3 cycles then high -> no `key_level`/`key_press`/`key_release` activity.
- `sw_raw` 42 -> 100 -> 123, with each intermediate value held 2 cycles, then 123 held -> exactly one `sw_changed`, `sw_stable`=123, `gpio_in`=0x7B.
- `key_raw[0]` low, `rst_n` pulsed low during PRESS_PEND -> outputs cleared. With the key still low, `key_press[0]` fires 6 cycles after `rst_n` rises.
- `key_raw[0]` and `key_raw[3]` fall in the same cycle -> `key_press[0]` and `key_press[3]` pulse in the same cycle. `key_level`=4'b1001.
